// File: rtl/pwm_duty_seq_pkg.sv
// Shared types and default widths for the PWM duty-cycle sequencer.
//   mode_e  : pattern selection as seen on mode_i (2'b11 is reserved and behaves as static)
//   state_e : sequencer FSM states
//   is_seq_mode() : true for the patterns that leave IDLE (blink, heartbeat)
package pwm_duty_seq_pkg;

  localparam int DW_DEF = 16;
  localparam int HW_DEF = 16;

  typedef enum logic [1:0] {
    MODE_STATIC    = 2'b00,
    MODE_BLINK     = 2'b01,
    MODE_HEARTBEAT = 2'b10
  } mode_e;

  // Unused codes decode back to IDLE in the FSM default branch.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_HOLD_A    = 3'b001,
    ST_HOLD_B    = 3'b010,
    ST_RAMP_UP   = 3'b011,
    ST_RAMP_DOWN = 3'b100
  } state_e;

  function automatic logic is_seq_mode(input logic [1:0] m);
    return (m == MODE_BLINK) || (m == MODE_HEARTBEAT);
  endfunction

endpackage

// File: rtl/pwm_duty_seq_hold.sv
// Hold counter for the duty sequencer: counts pulse cycles spent at a level.
// Ports:
//   clk, rst_n : core clock, asynchronous active-low reset
//   strobe     : pulse-cycle boundary; the counter only moves on a strobe
//   clear      : force the count to zero (priority over load)
//   load       : load load_val
//   load_val   : reload value (hold cycles minus 1)
//   zero       : count is zero
// Without clear/load a strobe decrements a non-zero count and leaves zero alone.
module pwm_duty_seq_hold #(
  parameter int HW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          strobe,
  input  logic          clear,
  input  logic          load,
  input  logic [HW-1:0] load_val,
  output logic          zero
);

  logic [HW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (strobe) begin
      if (clear)             cnt_q <= '0;
      else if (load)         cnt_q <= load_val;
      else if (cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pwm_duty_seq.sv
// Per-channel PWM duty-cycle sequencer (static / blink / heartbeat).
// Every state, duty and counter update happens only on cycle_end_i so the
// comparator never sees a duty change inside a pulse cycle.
// Ports:
//   clk_core_i, rst_core_ni : core clock, asynchronous active-low reset
//   cycle_end_i             : phase-counter wrap strobe, the only update strobe
//   en_i, mode_i            : enable and pattern, sampled on the strobe
//   duty_a_i, duty_b_i      : low/start level and high level
//   step_i                  : heartbeat increment per pulse cycle
//   hold_cnt_i              : pulse cycles at each level, minus 1
//   duty_o                  : registered duty to the comparator
//   busy_o                  : sequencer is not IDLE
//   seq_wrap_o              : one-cycle pulse on each return to HOLD_A
//   period_cnt_o            : saturating wrap count, only when
//                             PWM_DUTY_SEQ_PERIOD_CNT_EN is defined
module pwm_duty_seq
  import pwm_duty_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int HW = HW_DEF
) (
  input  logic          clk_core_i,
  input  logic          rst_core_ni,
  input  logic          cycle_end_i,
  input  logic          en_i,
  input  logic [1:0]    mode_i,
  input  logic [DW-1:0] duty_a_i,
  input  logic [DW-1:0] duty_b_i,
  input  logic [DW-1:0] step_i,
  input  logic [HW-1:0] hold_cnt_i,
  output logic [DW-1:0] duty_o,
  output logic          busy_o,
  output logic          seq_wrap_o
`ifdef PWM_DUTY_SEQ_PERIOD_CNT_EN
  ,
  output logic [15:0]   period_cnt_o
`endif
);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [DW-1:0] duty_q, duty_d;
  logic          wrap_q, wrap_d;
  logic          cnt_clear, cnt_load, hold_zero;

  // One extra bit so neither A+step nor duty+step can wrap.
  logic [DW:0] ramp_up_sum;
  logic [DW:0] ramp_dn_lim;
  logic        degen;

  assign ramp_up_sum = {1'b0, duty_q} + {1'b0, step_i};
  assign ramp_dn_lim = {1'b0, duty_a_i} + {1'b0, step_i};
  // A heartbeat with nothing to ramp over runs as a plain blink.
  assign degen = (step_i == '0) || (duty_b_i <= duty_a_i);

  pwm_duty_seq_hold #(.HW(HW)) u_hold (
    .clk      (clk_core_i),
    .rst_n    (rst_core_ni),
    .strobe   (cycle_end_i),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (hold_cnt_i),
    .zero     (hold_zero)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    duty_d    = duty_q;
    wrap_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    if (cycle_end_i) begin
      if ((state_q != ST_IDLE) && (!en_i || (mode_i != mode_q))) begin
        // Disable or a pattern change abandons the sequence; restart from IDLE.
        state_d   = ST_IDLE;
        duty_d    = duty_a_i;
        cnt_clear = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            duty_d = duty_a_i;
            if (en_i && is_seq_mode(mode_i)) begin
              state_d  = ST_HOLD_A;
              mode_d   = mode_e'(mode_i);
              cnt_load = 1'b1;
            end else begin
              cnt_clear = 1'b1;
            end
          end
          ST_HOLD_A: begin
            duty_d = duty_a_i;
            if (hold_zero) begin
              cnt_load = 1'b1;
              state_d  = (mode_q == MODE_HEARTBEAT && !degen) ? ST_RAMP_UP : ST_HOLD_B;
            end
          end
          ST_HOLD_B: begin
            // Duty shows B for the whole hold; the wrap marks the state
            // returning to HOLD_A, and A appears on the following strobe.
            duty_d = duty_b_i;
            if (hold_zero) begin
              cnt_load = 1'b1;
              if (mode_q == MODE_HEARTBEAT && !degen) begin
                state_d = ST_RAMP_DOWN;
              end else begin
                state_d = ST_HOLD_A;
                wrap_d  = 1'b1;
              end
            end
          end
          ST_RAMP_UP: begin
            // Reloading here keeps the B hold exact even though the counter
            // keeps moving on strobes during the ramp.
            if (degen || (ramp_up_sum >= {1'b0, duty_b_i})) begin
              duty_d   = duty_b_i;
              state_d  = ST_HOLD_B;
              cnt_load = 1'b1;
            end else begin
              duty_d = ramp_up_sum[DW-1:0];
            end
          end
          ST_RAMP_DOWN: begin
            if (degen || ({1'b0, duty_q} <= ramp_dn_lim)) begin
              duty_d   = duty_a_i;
              state_d  = ST_HOLD_A;
              wrap_d   = 1'b1;
              cnt_load = 1'b1;
            end else begin
              duty_d = duty_q - step_i;
            end
          end
          default: begin
            state_d   = ST_IDLE;
            duty_d    = duty_a_i;
            cnt_clear = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
    if (!rst_core_ni) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_STATIC;
      duty_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      wrap_q  <= wrap_d;
    end
  end

  assign duty_o     = duty_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign seq_wrap_o = wrap_q;

`ifdef PWM_DUTY_SEQ_PERIOD_CNT_EN
  logic [15:0] period_cnt_q;

  always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
    if (!rst_core_ni) begin
      period_cnt_q <= '0;
    end else if (cycle_end_i && (state_d == ST_IDLE)) begin
      period_cnt_q <= '0;
    end else if (wrap_d && (period_cnt_q != 16'hFFFF)) begin
      period_cnt_q <= period_cnt_q + 16'd1;
    end
  end

  assign period_cnt_o = period_cnt_q;
`endif

endmodule

// File: tb/tb_pwm_duty_seq.sv
// Directed bench for pwm_duty_seq: a vector table of per-strobe inputs and
// expected outputs, plus hand-written sequences for the multi-cycle cases.
module tb_pwm_duty_seq;

  localparam int DW = 16;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cycle_end;
  logic          en;
  logic [1:0]    mode;
  logic [DW-1:0] duty_a, duty_b, step;
  logic [HW-1:0] hold;
  logic [DW-1:0] duty;
  logic          busy, wrap;
`ifdef PWM_DUTY_SEQ_PERIOD_CNT_EN
  logic [15:0]   period_cnt;
`endif

  always #5 clk = ~clk;

  pwm_duty_seq #(.DW(DW), .HW(HW)) dut (
    .clk_core_i  (clk),
    .rst_core_ni (rst_n),
    .cycle_end_i (cycle_end),
    .en_i        (en),
    .mode_i      (mode),
    .duty_a_i    (duty_a),
    .duty_b_i    (duty_b),
    .step_i      (step),
    .hold_cnt_i  (hold),
    .duty_o      (duty),
    .busy_o      (busy),
    .seq_wrap_o  (wrap)
`ifdef PWM_DUTY_SEQ_PERIOD_CNT_EN
    ,
    .period_cnt_o (period_cnt)
`endif
  );

  typedef struct packed {
    logic        en;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] step;
    logic [15:0] hold;
    logic [15:0] exp_duty;
    logic        exp_busy;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic e, input logic [1:0] m, input logic [15:0] a, b, s, h,
                     input logic [15:0] d, input logic bz, input logic w);
    vec_t v;
    v.en = e; v.mode = m; v.a = a; v.b = b; v.step = s; v.hold = h;
    v.exp_duty = d; v.exp_busy = bz; v.exp_wrap = w;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Idle for gap clocks, then one strobe; returns at the negedge after the
  // sampling posedge so outputs are already updated.
  task automatic strobe(input int gap);
    repeat (gap) @(negedge clk);
    cycle_end = 1'b1;
    @(negedge clk);
    cycle_end = 1'b0;
  endtask

  task automatic set_in(input logic e, input logic [1:0] m, input logic [15:0] a, b, s, h);
    en = e; mode = m; duty_a = a; duty_b = b; step = s; hold = h;
  endtask

  initial begin
    rst_n = 1'b0; cycle_end = 1'b0;
    set_in(1'b0, 2'b00, 16'd100, 16'd0, 16'd0, 16'd0);

    // Static and reserved mode never leave IDLE.
    add(0, 2'b00, 100, 0, 0, 0, 100, 0, 0);
    add(1, 2'b00, 100, 0, 0, 0, 100, 0, 0);
    add(1, 2'b11, 100, 0, 0, 0, 100, 0, 0);
    // Blink A=10 B=90 hold=2: entry strobe, then 3 x A and 3 x B per period.
    add(1, 2'b01, 10, 90, 0, 2, 10, 1, 0);
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 3; k++) add(1, 2'b01, 10, 90, 0, 2, 10, 1, 0);
      add(1, 2'b01, 10, 90, 0, 2, 90, 1, 0);
      add(1, 2'b01, 10, 90, 0, 2, 90, 1, 0);
      add(1, 2'b01, 10, 90, 0, 2, 90, 1, 1);
    end
    add(0, 2'b01, 10, 90, 0, 2, 10, 0, 0);
    // Heartbeat A=0 B=10 step=4 hold=0.
    add(1, 2'b10, 0, 10, 4, 0, 0, 1, 0);
    add(1, 2'b10, 0, 10, 4, 0, 0, 1, 0);
    add(1, 2'b10, 0, 10, 4, 0, 4, 1, 0);
    add(1, 2'b10, 0, 10, 4, 0, 8, 1, 0);
    add(1, 2'b10, 0, 10, 4, 0, 10, 1, 0);
    add(1, 2'b10, 0, 10, 4, 0, 10, 1, 0);
    add(1, 2'b10, 0, 10, 4, 0, 6, 1, 0);
    add(1, 2'b10, 0, 10, 4, 0, 2, 1, 0);
    add(1, 2'b10, 0, 10, 4, 0, 0, 1, 1);
    add(1, 2'b10, 0, 10, 4, 0, 0, 1, 0);
    add(1, 2'b10, 0, 10, 4, 0, 4, 1, 0);
    add(0, 2'b10, 0, 10, 4, 0, 0, 0, 0);
    // Full-range heartbeat: the DW+1 sum must clamp instead of wrapping.
    add(1, 2'b10, 0, 16'hFFFF, 16'h8000, 0, 16'h0000, 1, 0);
    add(1, 2'b10, 0, 16'hFFFF, 16'h8000, 0, 16'h0000, 1, 0);
    add(1, 2'b10, 0, 16'hFFFF, 16'h8000, 0, 16'h8000, 1, 0);
    add(1, 2'b10, 0, 16'hFFFF, 16'h8000, 0, 16'hFFFF, 1, 0);
    add(1, 2'b10, 0, 16'hFFFF, 16'h8000, 0, 16'hFFFF, 1, 0);
    add(1, 2'b10, 0, 16'hFFFF, 16'h8000, 0, 16'h7FFF, 1, 0);
    add(1, 2'b10, 0, 16'hFFFF, 16'h8000, 0, 16'h0000, 1, 1);
    add(0, 2'b10, 0, 16'hFFFF, 16'h8000, 0, 16'h0000, 0, 0);
    // Degenerate heartbeat (step=0) runs as blink.
    add(1, 2'b10, 10, 90, 0, 0, 10, 1, 0);
    add(1, 2'b10, 10, 90, 0, 0, 10, 1, 0);
    add(1, 2'b10, 10, 90, 0, 0, 90, 1, 1);
    add(1, 2'b10, 10, 90, 0, 0, 10, 1, 0);
    add(1, 2'b10, 10, 90, 0, 0, 90, 1, 1);
    add(0, 2'b10, 10, 90, 0, 0, 10, 0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset duty", duty, 0);
    check("reset busy", busy, 0);
    check("reset wrap", wrap, 0);
    rst_n = 1'b1;

    // No strobe yet: duty must stay at its reset value.
    repeat (9) @(negedge clk);
    check("pre-strobe duty", duty, 0);
    check("pre-strobe busy", busy, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].en, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].step, vecs[i].hold);
      strobe(3);
      check($sformatf("vec%0d duty", i), duty, vecs[i].exp_duty);
      check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d wrap", i), wrap, vecs[i].exp_wrap);
      if (vecs[i].exp_wrap) begin
        @(negedge clk);
        check($sformatf("vec%0d wrap width", i), wrap, 0);
      end
    end

    // en drop between strobes during RAMP_UP: nothing moves until the strobe.
    set_in(1'b1, 2'b10, 16'd5, 16'd100, 16'd10, 16'd0);
    strobe(2); strobe(2); strobe(2);
    check("ramp duty", duty, 15);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("en-drop hold duty", duty, 15);
    check("en-drop hold busy", busy, 1);
    strobe(2);
    check("en-drop duty", duty, 5);
    check("en-drop busy", busy, 0);

    // Mode change 10->01 mid-ramp: IDLE, then blink restart at A.
    set_in(1'b1, 2'b10, 16'd5, 16'd100, 16'd10, 16'd0);
    strobe(2); strobe(2); strobe(2); strobe(2);
    check("ramp2 duty", duty, 25);
    mode = 2'b01;
    strobe(2);
    check("modesw duty", duty, 5);
    check("modesw busy", busy, 0);
    strobe(2);
    check("restart duty", duty, 5);
    check("restart busy", busy, 1);
    strobe(2);
    check("restart hold A", duty, 5);
    strobe(2);
    check("restart level B", duty, 100);

    // Asynchronous reset mid-operation, away from any clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst duty", duty, 0);
    check("async rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset together with a strobe: reset wins.
    set_in(1'b1, 2'b01, 16'd10, 16'd90, 16'd0, 16'd2);
    strobe(2);
    check("pre-collide busy", busy, 1);
    @(negedge clk);
    cycle_end = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    cycle_end = 1'b0;
    check("collide duty", duty, 0);
    check("collide busy", busy, 0);
    rst_n = 1'b1;

`ifdef PWM_DUTY_SEQ_PERIOD_CNT_EN
    // Three blink periods with hold=0 give three wraps in seven strobes.
    set_in(1'b1, 2'b01, 16'd10, 16'd90, 16'd0, 16'd0);
    for (int k = 0; k < 7; k++) strobe(2);
    check("period cnt", period_cnt, 3);
    en = 1'b0;
    strobe(2);
    check("period cnt clear", period_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
